// File: rtl/bcd_updown_counter_n.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter_n
//   Multi-digit BCD (decade) up/down counter with synchronous load, count
//   enable, terminal-count flag and a one-cycle wrap pulse.
//
//   Optional build macro: BCD_CNT_SATURATE_EN
//     defined   -> counter saturates at all-9 (up) / all-0 (down), wrapped = 0
//     undefined -> counter wraps all-9 -> all-0 (up) and all-0 -> all-9 (down)
//
// Parameters
//   DIGITS        number of BCD decades (1..8), count width = 4*DIGITS
//   CLEAR_TO_MAX  1: clear loads all digits with 9, 0: clear loads all zeros
//
// Ports
//   clk         in   rising-edge clock
//   clear       in   asynchronous active-high reset
//   en          in   count enable
//   up          in   direction, 1 = increment, 0 = decrement
//   load        in   synchronous load strobe (priority over en)
//   load_value  in   BCD value to load, digit i at [4i+3:4i]; digits >9 clamp to 9
//   count       out  registered BCD count
//   tc          out  terminal count (combinational), high the cycle before a wrap
//   wrapped     out  registered one-cycle pulse after a full wrap
// -----------------------------------------------------------------------------
module bcd_updown_counter_n #(
  parameter int DIGITS       = 2,
  parameter bit CLEAR_TO_MAX = 1'b1
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  wrapped
);

  localparam int W = 4 * DIGITS;

  // Replicate one BCD digit across every decade.
  function automatic logic [W-1:0] fill_digits(input logic [3:0] d);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < DIGITS; i++) begin
      v[4*i +: 4] = d;
    end
    return v;
  endfunction

  // Clamp any non-BCD digit (A..F) to 9, leaving valid digits untouched.
  function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        r[4*i +: 4] = 4'd9;
      end
    end
    return r;
  endfunction

  // One BCD step with a ripple borrow/carry: a digit moves only while every
  // lower digit has just rolled over (9->0 up, 0->9 down).
  function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input logic inc);
    logic [W-1:0] r;
    logic         c;
    logic [3:0]   d;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (c) begin
        if (inc) begin
          if (d == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = d + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            r[4*i +: 4] = 4'd9;
          end else begin
            r[4*i +: 4] = d - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  localparam logic [W-1:0] ALL_NINE  = fill_digits(4'd9);
  localparam logic [W-1:0] ALL_ZERO  = '0;
  localparam logic [W-1:0] CLEAR_VAL = CLEAR_TO_MAX ? ALL_NINE : ALL_ZERO;

  logic [W-1:0] count_p0;
  logic         wrapped_p0;
  logic [W-1:0] count_nxt;
  logic         wrapped_nxt;

  // Boundary of the current direction; load masks it because load wins.
  assign tc = en & ~load & (up ? (count_p0 == ALL_NINE) : (count_p0 == ALL_ZERO));

  always_comb begin
    count_nxt   = count_p0;
    wrapped_nxt = 1'b0;
    if (load) begin
      count_nxt = clamp_bcd(load_value);
    end else if (en) begin
      if (tc) begin
`ifdef BCD_CNT_SATURATE_EN
        count_nxt   = count_p0;
        wrapped_nxt = 1'b0;
`else
        count_nxt   = up ? ALL_ZERO : ALL_NINE;
        wrapped_nxt = 1'b1;
`endif
      end else begin
        count_nxt = bcd_step(count_p0, up);
      end
    end
  end

  // Stage p0: count / wrap registers
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      count_p0   <= CLEAR_VAL;
      wrapped_p0 <= 1'b0;
    end else begin
      count_p0   <= count_nxt;
      wrapped_p0 <= wrapped_nxt;
    end
  end

  assign count   = count_p0;
  assign wrapped = wrapped_p0;

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
module tb_bcd_updown_counter_n;

  logic       clk = 1'b0;
  logic       clear;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] load_value;
  logic [7:0] count;
  logic       tc;
  logic       wrapped;

  int total = 0;
  int bad   = 0;

`ifdef BCD_CNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  bcd_updown_counter_n #(.DIGITS(2), .CLEAR_TO_MAX(1'b1)) dut (
    .clk        (clk),
    .clear      (clear),
    .en         (en),
    .up         (up),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .tc         (tc),
    .wrapped    (wrapped)
  );

  always #5 clk = ~clk;

  // Decimal 0..99 to two-digit BCD.
  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_value = 8'h00;
    #3;
    total++;
    if (count !== 8'h99) begin bad++; $display("FAIL reset_count got=%h exp=99", count); end
    total++;
    if (wrapped !== 1'b0) begin bad++; $display("FAIL reset_wrapped got=%b exp=0", wrapped); end
    clear = 1'b0;
    tick();
    load = 1'b1; load_value = 8'h42;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b0;
    total++;
    if (count !== 8'h42) begin bad++; $display("FAIL reset_preload got=%h exp=42", count); end
    #2;
    clear = 1'b1;
    #1;
    total++;
    if (count !== 8'h99) begin bad++; $display("FAIL reset_midcount got=%h exp=99", count); end
    total++;
    if (wrapped !== 1'b0) begin bad++; $display("FAIL reset_mid_wrapped got=%b exp=0", wrapped); end
    en = 1'b0;
    #1;
    clear = 1'b0;
    tick();
  endtask

  task automatic test_down();
    int  val;
    bit  wexp;
    clear = 1'b1;
    #1;
    clear = 1'b0;
    load = 1'b0; en = 1'b1; up = 1'b0;
    val = 99;
    for (int k = 0; k < 100; k++) begin
      total++;
      if (tc !== (val == 0)) begin bad++; $display("FAIL down_tc k=%0d got=%b exp=%b", k, tc, (val == 0)); end
      wexp = 1'b0;
      if (val == 0) begin
        if (!SAT) begin val = 99; wexp = 1'b1; end
      end else begin
        val = val - 1;
      end
      tick();
      total++;
      if (count !== to_bcd(val)) begin bad++; $display("FAIL down_count k=%0d got=%h exp=%h", k, count, to_bcd(val)); end
      total++;
      if (wrapped !== wexp) begin bad++; $display("FAIL down_wrapped k=%0d got=%b exp=%b", k, wrapped, wexp); end
    end
    en = 1'b0;
    tick();
    total++;
    if (wrapped !== 1'b0) begin bad++; $display("FAIL down_wrap_pulse got=%b exp=0", wrapped); end
  endtask

  task automatic test_up();
    logic [7:0] exp_seq [3] = '{8'h09, 8'h10, 8'h11};
    load = 1'b1; load_value = 8'h08; en = 1'b0;
    tick();
    load = 1'b0;
    total++;
    if (count !== 8'h08) begin bad++; $display("FAIL up_load got=%h exp=08", count); end
    en = 1'b1; up = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (count !== exp_seq[k]) begin bad++; $display("FAIL up_seq k=%0d got=%h exp=%h", k, count, exp_seq[k]); end
    end
    load = 1'b1; load_value = 8'h98;
    tick();
    load = 1'b0;
    total++;
    if (tc !== 1'b0) begin bad++; $display("FAIL up_tc98 got=%b exp=0", tc); end
    tick();
    total++;
    if (count !== 8'h99) begin bad++; $display("FAIL up_99 got=%h exp=99", count); end
    total++;
    if (tc !== 1'b1) begin bad++; $display("FAIL up_tc99 got=%b exp=1", tc); end
    tick();
    total++;
    if (count !== (SAT ? 8'h99 : 8'h00)) begin bad++; $display("FAIL up_wrap_count got=%h exp=%h", count, (SAT ? 8'h99 : 8'h00)); end
    total++;
    if (wrapped !== !SAT) begin bad++; $display("FAIL up_wrapped got=%b exp=%b", wrapped, !SAT); end
    en = 1'b0;
    tick();
    total++;
    if (wrapped !== 1'b0) begin bad++; $display("FAIL up_wrap_clear got=%b exp=0", wrapped); end
  endtask

  task automatic test_load_clamp();
    load = 1'b1; en = 1'b1; up = 1'b1; load_value = 8'h3C;
    #1;
    total++;
    if (tc !== 1'b0) begin bad++; $display("FAIL clamp_tc_load got=%b exp=0", tc); end
    tick();
    load = 1'b0; en = 1'b0;
    total++;
    if (count !== 8'h39) begin bad++; $display("FAIL clamp_3C got=%h exp=39", count); end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (count !== 8'h39) begin bad++; $display("FAIL clamp_hold k=%0d got=%h exp=39", k, count); end
      total++;
      if (tc !== 1'b0) begin bad++; $display("FAIL clamp_hold_tc k=%0d got=%b exp=0", k, tc); end
    end
    load = 1'b1; load_value = 8'hA5;
    tick();
    total++;
    if (count !== 8'h95) begin bad++; $display("FAIL clamp_A5 got=%h exp=95", count); end
    load_value = 8'hFA;
    tick();
    total++;
    if (count !== 8'h99) begin bad++; $display("FAIL clamp_FA got=%h exp=99", count); end
    // load beats en at the wrap boundary: tc masked, no wrap
    en = 1'b1; up = 1'b1; load_value = 8'h57;
    #1;
    total++;
    if (tc !== 1'b0) begin bad++; $display("FAIL prio_tc got=%b exp=0", tc); end
    tick();
    total++;
    if (count !== 8'h57) begin bad++; $display("FAIL prio_count got=%h exp=57", count); end
    total++;
    if (wrapped !== 1'b0) begin bad++; $display("FAIL prio_wrapped got=%b exp=0", wrapped); end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_direction();
    load = 1'b1; load_value = 8'h10; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b0;
    tick();
    total++;
    if (count !== 8'h09) begin bad++; $display("FAIL dir_down got=%h exp=09", count); end
    up = 1'b1;
    tick();
    total++;
    if (count !== 8'h10) begin bad++; $display("FAIL dir_up got=%h exp=10", count); end
    en = 1'b0;
  endtask

`ifdef BCD_CNT_SATURATE_EN
  task automatic test_saturate();
    logic [7:0] dseq [4] = '{8'h01, 8'h00, 8'h00, 8'h00};
    load = 1'b1; load_value = 8'h02; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (count !== dseq[k]) begin bad++; $display("FAIL sat_down k=%0d got=%h exp=%h", k, count, dseq[k]); end
      total++;
      if (wrapped !== 1'b0) begin bad++; $display("FAIL sat_down_wrapped k=%0d got=%b exp=0", k, wrapped); end
    end
    total++;
    if (tc !== 1'b1) begin bad++; $display("FAIL sat_down_tc got=%b exp=1", tc); end
    load = 1'b1; load_value = 8'h98; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      total++;
      if (count !== 8'h99) begin bad++; $display("FAIL sat_up k=%0d got=%h exp=99", k, count); end
      total++;
      if (wrapped !== 1'b0) begin bad++; $display("FAIL sat_up_wrapped k=%0d got=%b exp=0", k, wrapped); end
    end
    en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_down();
    test_up();
    test_load_clamp();
    test_direction();
`ifdef BCD_CNT_SATURATE_EN
    test_saturate();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter_n.md
Name: bcd_updown_counter_n

Overview:
- Parametrised multi-digit BCD (decadic) up/down counter with synchronous load, count enable and terminal-count flag.
- Generalises the single-digit 4-bit decade down counter to DIGITS cascaded decades, selectable direction and a configurable clear value.
- Used as a timer/event-counter building block feeding display decoders in later guides.

Parameters:
- DIGITS, 2, number of BCD decades (1..8); count width = 4*DIGITS.
- CLEAR_TO_MAX, 1, 1: clear loads all digits with 9 (e.g. 99); 0: clear loads all digits with 0.

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  asynchronous, active-high reset.
- en  input  1  count enable; sampled on rising clk.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous load strobe.
- load_value  input  4*DIGITS  BCD value to load; digit i at bits [4i+3:4i], digit 0 = least significant.
- count  output  4*DIGITS  registered BCD count.
- tc  output  1  terminal count, combinational.
- wrapped  output  1  registered one-cycle pulse after a wrap.

Behaviour:
- Reset: while clear=1, count = all-9 if CLEAR_TO_MAX=1, else all-0; wrapped = 0. Asynchronous, takes effect without clk. It overrides load/en at any time, including mid-count.
- Priority per rising clk edge (clear low): load > en > hold.
- load=1:
  - count <= load_value next cycle, regardless of en.
  - Any loaded digit >9 is clamped to 9; other digits are unaffected.
  - wrapped <= 0.
- en=1, up=1:
  - Digit 0 increments.
  - Digit i>0 increments only when all lower digits are 9; digits that are 9 and roll over become 0.
- en=1, up=0:
  - Digit 0 decrements.
  - Digit i>0 decrements only when all lower digits are 0; digits that are 0 and roll under become 9.
- Full wrap:
  - up at all-9 goes to all-0.
  - down at all-0 goes to all-9.
  - In either case wrapped <= 1 for exactly one cycle; otherwise wrapped <= 0.
- en=0 and load=0: count holds; wrapped <= 0.
- tc = en & ~load & (up ? count==all-9 : count==all-0). It is high during the cycle before a wrap edge.
- Direction change takes effect on the next enabled edge; there is no extra latency.
- Latency: one clk from en/load to count update. count always holds valid BCD, digits 0..9.

Optional Feature:
- Macro: BCD_CNT_SATURATE_EN.
- Defined:
  - The counter saturates instead of wrapping: up at all-9 holds all-9, down at all-0 holds all-0.
  - wrapped stays 0.
  - tc keeps the same definition, marking the saturation boundary.
- Undefined: wrap behaviour as above.

Test Plan:
(All cases use DIGITS=2, CLEAR_TO_MAX=1, macro undefined unless stated.)
- Assert clear asynchronously between edges: count becomes 8'h99 immediately, wrapped=0. Repeat mid-count at 8'h42: count becomes 8'h99 without a clock.
- Down count from clear, en=1, up=0, for 100 edges:
  - Sequence is 99,98,...,90,89,...,01,00, then 99.
  - tc=1 only while count=00.
  - wrapped=1 for the single cycle after 00 goes to 99.
- Up count from load_value=8'h08 with en=1, up=1: sequence is 08,09,10,11. At count=99, tc=1; the next edge gives 00 and wrapped=1.
- load=1 with en=1, load_value=8'h3C: count becomes 8'h39 (digit clamped). Then load=0, en=0 for 3 edges: count holds 39, tc=0.
- Direction toggle: at 8'h10, up=0 gives 09; up=1 then gives 10 on the following edge.
- With BCD_CNT_SATURATE_EN defined:
  - Down from 02 gives 01, 00, 00, 00 with wrapped=0.
  - Up from 98 gives 99, 99.
